// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Instruction fetch stage of the single-issue MIPS core. It owns the PC,
// fetches one 32-bit word at a time from instruction memory and presents it to
// the decoder. When the decoder accepts the word, the fetch unit picks the next
// PC from the resolved branch/jump outcome, which is returned on that same
// accept cycle.
//
// Ports
//   clk, reset             single clock; synchronous active-high reset
//   imem_req/imem_addr     fetch request to memory and the word address (= pc)
//   imem_ready/imem_rdata  memory data return; only meaningful while imem_req=1
//   instr_valid/ready      valid/ready handshake toward the decoder
//   instr/instr_pc         held instruction and its address
//   pc_plus4               instr_pc + 4 (wraps mod 2^32)
//   branch_taken/imm       branch outcome and immediate, sampled on accept
//   jump/jump_index        jump outcome and 26-bit index, sampled on accept
//   fetch_count            number of accepted instructions since reset (wraps)
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ready,
  input  logic [31:0]      imem_rdata,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [31:0]      instr,
  output logic [31:0]      instr_pc,
  output logic [31:0]      pc_plus4,
  input  logic             branch_taken,
  input  logic [15:0]      branch_imm,
  input  logic             jump,
  input  logic [25:0]      jump_index,
  output logic [CNT_W-1:0] fetch_count
);

  typedef enum logic {
    S_FETCH = 1'b0,
    S_HOLD  = 1'b1
  } state_e;

  state_e             state_q,       state_d;
  logic [31:0]        pc_q,          pc_d;
  logic [31:0]        instr_q,       instr_d;
  logic [31:0]        instr_pc_q,    instr_pc_d;
  logic [CNT_W-1:0]   fetch_count_q, fetch_count_d;

  logic [31:0]        pc_plus4_w;
  logic [31:0]        branch_off;
  logic [31:0]        next_pc;

  // Redirect target. Only used on the accept cycle, where instr_pc_q == pc_q.
  assign pc_plus4_w = instr_pc_q + 32'd4;
  assign branch_off = {{14{branch_imm[15]}}, branch_imm, 2'b00};

  always_comb begin
    if (jump) begin
      // Jump wins over a simultaneous taken branch.
      next_pc = {pc_plus4_w[31:28], jump_index, 2'b00};
    end else if (branch_taken) begin
      next_pc = pc_plus4_w + branch_off;
    end else begin
      next_pc = pc_plus4_w;
    end
  end

  always_comb begin
    // NOTE: every variable gets a default first, so no path leaves it
    // unassigned and no latch can be inferred.
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    fetch_count_d = fetch_count_q;

    unique case (state_q)
      S_FETCH: begin
        if (imem_ready) begin
          instr_d    = imem_rdata;
          instr_pc_d = pc_q;
          state_d    = S_HOLD;
        end
      end
      S_HOLD: begin
        if (instr_ready) begin
          fetch_count_d = fetch_count_q + CNT_W'(1);
          pc_d          = next_pc;
          state_d       = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q       <= S_FETCH;
      pc_q          <= RESET_PC;
      instr_q       <= 32'd0;
      instr_pc_q    <= RESET_PC;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  // Handshake outputs are gated by reset so nothing is offered or requested
  // during a reset cycle, even one that arrives mid-transaction.
  assign imem_req    = ~reset & (state_q == S_FETCH);
  assign instr_valid = ~reset & (state_q == S_HOLD);
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign pc_plus4    = pc_plus4_w;
  assign fetch_count = fetch_count_q;

endmodule
